// File: rtl/rmw_dual_ram_engine_pkg.sv
// rtl/rmw_dual_ram_engine_pkg.sv - shared types and the word-pair transform for the RMW sweep engine
package rmw_engine_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ_WRITE,
      S_LAST_WRITE,
      S_DONE
   } state_t;

   typedef enum logic [1:0] {
      MODE_XFORM,
      MODE_SWAP,
      MODE_SAT,
      MODE_COPY
   } mode_t;

   typedef struct packed {
      logic signed [31:0] a;
      logic signed [31:0] b;
      logic               ovf;
   } xform_res_t;

   // Results are exact in 32 bits; the caller keeps the low data_w bits, which wraps.
   function automatic xform_res_t rmw_xform(input mode_t mode,
                                            input logic signed [31:0] a,
                                            input logic signed [31:0] b,
                                            input int data_w,
                                            input logic low);
      logic signed [31:0] lim_hi;
      logic signed [31:0] lim_lo;
      logic signed [31:0] ra;
      logic signed [31:0] rb;
      xform_res_t         res;
      lim_hi  = (32'sd1 <<< (data_w - 1)) - 32'sd1;
      lim_lo  = -lim_hi - 32'sd1;
      ra      = a;
      rb      = b;
      res.ovf = 1'b0;
      case (mode)
         MODE_XFORM: begin
            if (low) begin
               if (a >= 0) begin
                  ra = a - 32'sd1;
                  rb = b + 32'sd1;
               end else begin
                  ra = b - 32'sd1;
                  rb = a + 32'sd1;
               end
            end else if (b < 0) begin
               ra = b - a;
               rb = a + b;
            end else begin
               ra = a + b;
               rb = a - b;
            end
            res.ovf = (ra > lim_hi) || (ra < lim_lo) || (rb > lim_hi) || (rb < lim_lo);
         end
         MODE_SWAP: begin
            ra = b;
            rb = a;
         end
         MODE_SAT: begin
            ra = a + b;
            rb = a - b;
            if (ra > lim_hi) ra = lim_hi;
            if (ra < lim_lo) ra = lim_lo;
            if (rb > lim_hi) rb = lim_hi;
            if (rb < lim_lo) rb = lim_lo;
         end
         default: begin
            ra = a;
            rb = b;
         end
      endcase
      res.a = ra;
      res.b = rb;
      return res;
   endfunction

endpackage

// File: rtl/rmw_dual_ram_engine_if.sv
// rtl/rmw_dual_ram_engine_if.sv - host/controller bundle for the RMW sweep engine
interface rmw_dual_ram_engine_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 9
);
   logic              START_I;
   logic [1:0]        MODE_I;
   logic [ADDR_W-1:0] START_ADDR_I;
   logic [ADDR_W-1:0] LAST_ADDR_I;
   logic              ABORT_I;
   logic              HOST_WE_I;
   logic              HOST_SEL_I;
   logic [ADDR_W-1:0] HOST_ADDR_I;
   logic [DATA_W-1:0] HOST_DATA_I;
   logic [DATA_W-1:0] HOST_RDATA_O;
   logic              BUSY_O;
   logic              DONE_O;
   logic              OVF_O;

   modport master (
      output START_I, MODE_I, START_ADDR_I, LAST_ADDR_I, ABORT_I,
      output HOST_WE_I, HOST_SEL_I, HOST_ADDR_I, HOST_DATA_I,
      input  HOST_RDATA_O, BUSY_O, DONE_O, OVF_O
   );

   modport slave (
      input  START_I, MODE_I, START_ADDR_I, LAST_ADDR_I, ABORT_I,
      input  HOST_WE_I, HOST_SEL_I, HOST_ADDR_I, HOST_DATA_I,
      output HOST_RDATA_O, BUSY_O, DONE_O, OVF_O
   );
endinterface

// File: rtl/rmw_dual_ram_engine_ram.sv
// rtl/rmw_dual_ram_engine_ram.sv - dual-port RAM, registered read on port A, write on port B
module dual_port_ram_param #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 9
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] i_addr_a,
   output logic [DATA_W-1:0] o_q_a,
   input  logic              i_we_b,
   input  logic [ADDR_W-1:0] i_addr_b,
   input  logic [DATA_W-1:0] i_data_b
);
   logic [DATA_W-1:0] r_mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (i_we_b) r_mem[i_addr_b] <= i_data_b;
      o_q_a <= r_mem[i_addr_a];
   end
endmodule

// File: rtl/rmw_dual_ram_engine.sv
// rtl/rmw_dual_ram_engine.sv - wrapping read-modify-write sweep over two word RAMs with host access when idle
module rmw_dual_ram_engine
   import rmw_engine_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 9,
   parameter int SPLIT  = 256
) (
   input  logic                 CLOCK_50_I,
   input  logic                 RESET_I,
   rmw_dual_ram_engine_if.slave bus
);
   localparam logic [ADDR_W:0] SPLIT_L = (ADDR_W + 1)'(SPLIT);

   state_t            r_state;
   mode_t             r_mode;
   logic [ADDR_W-1:0] r_rd_addr;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [ADDR_W-1:0] r_last;
   logic              r_we;
   logic              r_busy;
   logic              r_done;
   logic              r_ovf;

   logic [ADDR_W-1:0] w_addr_a;
   logic [ADDR_W-1:0] w_addr_b;
   logic [DATA_W-1:0] w_q0;
   logic [DATA_W-1:0] w_q1;
   logic signed [31:0] w_a;
   logic signed [31:0] w_b;
   logic              w_low;
   xform_res_t        w_res;
   logic              w_host_we;
   logic              w_we0;
   logic              w_we1;
   logic [DATA_W-1:0] w_d0;
   logic [DATA_W-1:0] w_d1;

   // Port A follows the sweep only while reads are being issued; otherwise the host owns it.
   assign w_addr_a  = (r_state == S_READ_WRITE) ? r_rd_addr : bus.HOST_ADDR_I;
   assign w_host_we = (r_state == S_IDLE) && bus.HOST_WE_I;
   assign w_addr_b  = r_we ? r_wr_addr : bus.HOST_ADDR_I;
   assign w_we0     = r_we || (w_host_we && !bus.HOST_SEL_I);
   assign w_we1     = r_we || (w_host_we && bus.HOST_SEL_I);

   assign w_a   = {{(32 - DATA_W){w_q0[DATA_W-1]}}, w_q0};
   assign w_b   = {{(32 - DATA_W){w_q1[DATA_W-1]}}, w_q1};
   assign w_low = {1'b0, r_wr_addr} < SPLIT_L;
   assign w_res = rmw_xform(r_mode, w_a, w_b, DATA_W, w_low);

   assign w_d0 = r_we ? w_res.a[DATA_W-1:0] : bus.HOST_DATA_I;
   assign w_d1 = r_we ? w_res.b[DATA_W-1:0] : bus.HOST_DATA_I;

   dual_port_ram_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram0 (
      .clk      (CLOCK_50_I),
      .i_addr_a (w_addr_a),
      .o_q_a    (w_q0),
      .i_we_b   (w_we0),
      .i_addr_b (w_addr_b),
      .i_data_b (w_d0)
   );

   dual_port_ram_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram1 (
      .clk      (CLOCK_50_I),
      .i_addr_a (w_addr_a),
      .o_q_a    (w_q1),
      .i_we_b   (w_we1),
      .i_addr_b (w_addr_b),
      .i_data_b (w_d1)
   );

   always_ff @(posedge CLOCK_50_I or posedge RESET_I) begin
      if (RESET_I) begin
         r_state   <= S_IDLE;
         r_mode    <= MODE_XFORM;
         r_rd_addr <= '0;
         r_wr_addr <= '0;
         r_last    <= '0;
         r_we      <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_ovf     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (bus.START_I) begin
                  r_mode    <= mode_t'(bus.MODE_I);
                  r_rd_addr <= bus.START_ADDR_I;
                  r_last    <= bus.LAST_ADDR_I;
                  r_ovf     <= 1'b0;
                  r_busy    <= 1'b1;
                  r_state   <= S_READ_WRITE;
               end
            end
            S_READ_WRITE: begin
               r_rd_addr <= r_rd_addr + 1'b1;
               r_wr_addr <= r_rd_addr;
               r_we      <= 1'b1;
               if ((r_rd_addr == r_last) || bus.ABORT_I) r_state <= S_LAST_WRITE;
            end
            S_LAST_WRITE: begin
               r_we    <= 1'b0;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= S_DONE;
            end
            default: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
         if (r_we && w_res.ovf) r_ovf <= 1'b1;
      end
   end

   assign bus.HOST_RDATA_O = bus.HOST_SEL_I ? w_q1 : w_q0;
   assign bus.BUSY_O       = r_busy;
   assign bus.DONE_O       = r_done;
   assign bus.OVF_O        = r_ovf;
endmodule

// File: tb/tb_rmw_dual_ram_engine.sv
// tb/tb_rmw_dual_ram_engine.sv - randomized sweeps checked against an array model of both RAMs
module tb_rmw_dual_ram_engine;
   localparam int DW    = 8;
   localparam int AW    = 9;
   localparam int DEPTH = 512;
   localparam int SPLIT = 256;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rmw_dual_ram_engine_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   rmw_dual_ram_engine #(.DATA_W(DW), .ADDR_W(AW), .SPLIT(SPLIT)) dut (
      .CLOCK_50_I (clk),
      .RESET_I    (rst),
      .bus        (bus)
   );

   int m0 [DEPTH];
   int m1 [DEPTH];
   bit m_ovf;
   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int wrap8(input int x);
      int y;
      y = x & 255;
      return (y > 127) ? y - 256 : y;
   endfunction

   function automatic bit oor(input int x);
      return (x < -128) || (x > 127);
   endfunction

   function automatic int sat8(input int x);
      return (x > 127) ? 127 : ((x < -128) ? -128 : x);
   endfunction

   task automatic model_word(input int mode, input int addr);
      int a, b, na, nb;
      a = m0[addr];
      b = m1[addr];
      case (mode)
         0: begin
            if (addr < SPLIT) begin
               if (a >= 0) begin na = a - 1; nb = b + 1; end
               else        begin na = b - 1; nb = a + 1; end
            end else if (b < 0) begin
               na = b - a; nb = a + b;
            end else begin
               na = a + b; nb = a - b;
            end
            if (oor(na) || oor(nb)) m_ovf = 1'b1;
         end
         1: begin na = b; nb = a; end
         2: begin na = sat8(a + b); nb = sat8(a - b); end
         default: begin na = a; nb = b; end
      endcase
      m0[addr] = wrap8(na);
      m1[addr] = wrap8(nb);
   endtask

   task automatic host_write(input int sel, input int addr, input int data);
      @(negedge clk);
      bus.HOST_WE_I   = 1'b1;
      bus.HOST_SEL_I  = sel[0];
      bus.HOST_ADDR_I = 9'(addr);
      bus.HOST_DATA_I = 8'(data);
      if (sel != 0) m1[addr] = wrap8(data);
      else          m0[addr] = wrap8(data);
   endtask

   task automatic host_read(input int sel, input int addr, output int v);
      logic signed [7:0] t;
      @(negedge clk);
      bus.HOST_WE_I   = 1'b0;
      bus.HOST_SEL_I  = sel[0];
      bus.HOST_ADDR_I = 9'(addr);
      @(negedge clk);
      t = bus.HOST_RDATA_O;
      v = t;
   endtask

   task automatic readback_all(input string tag);
      logic signed [7:0] t;
      for (int a = 0; a < DEPTH; a++) begin
         @(negedge clk);
         bus.HOST_WE_I   = 1'b0;
         bus.HOST_SEL_I  = 1'b0;
         bus.HOST_ADDR_I = 9'(a);
         @(negedge clk);
         t = bus.HOST_RDATA_O;
         chk($sformatf("%s ram0[%0d]", tag, a), t, m0[a]);
         bus.HOST_SEL_I = 1'b1;
         #1;
         t = bus.HOST_RDATA_O;
         chk($sformatf("%s ram1[%0d]", tag, a), t, m1[a]);
      end
   endtask

   task automatic run_sweep(input int mode, input int s, input int l, input int abort_at,
                            input bit disturb, input string tag);
      int nfull, n, cyc, busy, done_cyc;
      nfull = ((l - s) % DEPTH + DEPTH) % DEPTH + 1;
      n     = (abort_at > 0 && abort_at < nfull) ? abort_at : nfull;
      m_ovf = 1'b0;
      for (int k = 0; k < n; k++) model_word(mode, (s + k) % DEPTH);
      @(negedge clk);
      bus.HOST_WE_I    = 1'b0;
      bus.START_I      = 1'b1;
      bus.MODE_I       = 2'(mode);
      bus.START_ADDR_I = 9'(s);
      bus.LAST_ADDR_I  = 9'(l);
      @(negedge clk);
      bus.START_I = 1'b0;
      if (disturb) begin
         bus.MODE_I       = 2'(mode + 1);
         bus.START_ADDR_I = 9'(0);
         bus.LAST_ADDR_I  = 9'(0);
         bus.HOST_SEL_I   = 1'b0;
         bus.HOST_ADDR_I  = 9'(200);
         bus.HOST_DATA_I  = 8'(77);
      end
      cyc = 1; busy = 0; done_cyc = 0;
      while (cyc < 2000) begin
         bus.ABORT_I = (cyc == abort_at);
         if (disturb) begin
            bus.START_I   = (cyc == 2);
            bus.HOST_WE_I = (cyc == 2);
         end
         if (bus.BUSY_O) busy++;
         if (bus.DONE_O) begin
            done_cyc = cyc;
            break;
         end
         @(negedge clk);
         cyc++;
      end
      bus.ABORT_I   = 1'b0;
      bus.START_I   = 1'b0;
      bus.HOST_WE_I = 1'b0;
      chk({tag, " busy_cycles"}, busy, n + 1);
      chk({tag, " done_cycle"}, done_cyc, n + 2);
      chk({tag, " ovf_at_done"}, bus.OVF_O, m_ovf);
      @(negedge clk);
      chk({tag, " done_one_cycle"}, bus.DONE_O, 0);
      chk({tag, " busy_after"}, bus.BUSY_O, 0);
      chk({tag, " ovf_held"}, bus.OVF_O, m_ovf);
   endtask

   initial begin
      int v, mode, s, len;
      rst              = 1'b1;
      bus.START_I      = 1'b0;
      bus.MODE_I       = 2'd0;
      bus.START_ADDR_I = '0;
      bus.LAST_ADDR_I  = '0;
      bus.ABORT_I      = 1'b0;
      bus.HOST_WE_I    = 1'b0;
      bus.HOST_SEL_I   = 1'b0;
      bus.HOST_ADDR_I  = '0;
      bus.HOST_DATA_I  = '0;
      repeat (3) @(negedge clk);
      chk("reset busy", bus.BUSY_O, 0);
      chk("reset done", bus.DONE_O, 0);
      chk("reset ovf", bus.OVF_O, 0);
      rst = 1'b0;

      for (int i = 0; i < DEPTH; i++) begin
         host_write(0, i, i - 128);
         host_write(1, i, 5);
      end
      run_sweep(0, 0, 511, 0, 1'b0, "full");
      host_read(0, 0, v);   chk("full a0", v, 4);
      host_read(1, 0, v);   chk("full b0", v, -127);
      host_read(0, 200, v); chk("full a200", v, 71);
      host_read(1, 200, v); chk("full b200", v, 6);
      host_read(0, 300, v); chk("full a300", v, -79);
      host_read(1, 300, v); chk("full b300", v, -89);
      readback_all("full");

      host_write(0, 300, 100);
      host_write(1, 300, 100);
      run_sweep(0, 300, 300, 0, 1'b0, "ovf");
      chk("ovf flag", bus.OVF_O, 1);
      host_read(0, 300, v); chk("ovf a300", v, -56);
      host_read(1, 300, v); chk("ovf b300", v, 0);
      chk("ovf sticky idle", bus.OVF_O, 1);

      host_write(0, 5, 100);
      host_write(1, 5, 100);
      host_write(0, 6, -100);
      host_write(1, 6, 100);
      run_sweep(2, 5, 6, 0, 1'b0, "sat");
      chk("sat ovf", bus.OVF_O, 0);
      host_read(0, 5, v); chk("sat a5", v, 127);
      host_read(1, 5, v); chk("sat b5", v, 0);
      host_read(0, 6, v); chk("sat a6", v, 0);
      host_read(1, 6, v); chk("sat b6", v, -128);

      run_sweep(1, 510, 1, 0, 1'b0, "swap");
      readback_all("swap");

      run_sweep(0, 10, 100, 3, 1'b0, "abort");
      readback_all("abort");

      run_sweep(3, 40, 60, 0, 1'b1, "busy_ignore");
      host_read(0, 200, v); chk("busy host write dropped", v, m0[200]);

      for (int i = 300; i < 306; i++) begin
         host_write(0, i, 100);
         host_write(1, i, 100);
      end
      @(negedge clk);
      bus.HOST_WE_I    = 1'b0;
      bus.START_I      = 1'b1;
      bus.MODE_I       = 2'd0;
      bus.START_ADDR_I = 9'(300);
      bus.LAST_ADDR_I  = 9'(305);
      @(negedge clk);
      bus.START_I = 1'b0;
      repeat (4) @(negedge clk);
      chk("pre-reset busy", bus.BUSY_O, 1);
      chk("pre-reset ovf", bus.OVF_O, 1);
      rst = 1'b1;
      #1;
      chk("mid reset busy", bus.BUSY_O, 0);
      chk("mid reset done", bus.DONE_O, 0);
      chk("mid reset ovf", bus.OVF_O, 0);
      for (int k = 0; k < 3; k++) model_word(0, 300 + k);
      @(negedge clk);
      rst = 1'b0;
      readback_all("reset");

      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 20; k++)
            host_write(int'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
                       int'($urandom_range(0, 255)));
         mode = int'($urandom_range(0, 3));
         s    = int'($urandom_range(0, DEPTH - 1));
         len  = int'($urandom_range(1, 64));
         run_sweep(mode, s, (s + len - 1) % DEPTH, 0, 1'b0, $sformatf("rand%0d", r));
         readback_all($sformatf("rand%0d", r));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
